qs_srt_fetch: RTL and testbench

Instruction fetch stage for the SRT micro-sequencer. Holds the program counter and issues reads to the synchronous microcode ROM. Buffers returned instructions in a 2-entry queue and presents them with a valid/ready handshake to the microcode decoder. Redirects from execute on taken JCC/CALL/RET, and halts on DONE.

---
 rtl/qs_srt_pkg.sv | 22 ++
 rtl/qs_srt_fetch_queue.sv | 59 +++++
 rtl/qs_srt_fetch.sv | 100 ++++++++++
 tb/tb_qs_srt_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/qs_srt_pkg.sv
// Shared types for the SRT micro-sequencer fetch stage.
package qs_srt_pkg;

    localparam int unsigned SRT_PC_W    = 8;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned FETCH_Q_N   = 2;
    localparam int unsigned FETCH_CNT_W = 2;

    typedef logic [SRT_PC_W-1:0] pc_t;
    typedef logic [INST_W-1:0]   inst_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        inst_t inst;
        pc_t   pc;
    } fetch_entry_t;

endpackage

// File: rtl/qs_srt_fetch_queue.sv
// Two-entry fetch FIFO; head is always entry 0 so it comes straight from a register.
module qs_srt_fetch_queue
    import qs_srt_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic [FETCH_CNT_W-1:0] count
);

    fetch_entry_t           ent0;
    fetch_entry_t           ent1;
    logic [FETCH_CNT_W-1:0] cnt;
    logic                   pop_ok;

    assign pop_ok = pop & (cnt != FETCH_CNT_W'(0));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (cnt == FETCH_CNT_W'(0)) ent0 <= push_data;
                    else                        ent1 <= push_data;
                    cnt <= cnt + FETCH_CNT_W'(1);
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - FETCH_CNT_W'(1);
                end
                // Full push+pop shifts the younger entry up and refills the tail.
                2'b11: begin
                    if (cnt == FETCH_CNT_W'(1)) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = ent0;
    assign empty = (cnt == FETCH_CNT_W'(0));
    assign count = cnt;

endmodule

// File: rtl/qs_srt_fetch.sv
// Fetch stage: PC, ROM issue, 2-entry instruction queue, redirect/halt handling.
module qs_srt_fetch
    import qs_srt_pkg::*;
#(
    parameter int unsigned PC_W = 8,
    parameter int unsigned Q_N  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_vld,
    input  logic [PC_W-1:0] start_pc,
    output logic            start_rdy,
    output logic            rom_en,
    output logic [PC_W-1:0] rom_addr,
    input  inst_t           rom_dout,
    input  logic            redirect_vld,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_vld,
    output inst_t           fetch_inst,
    output logic [PC_W-1:0] fetch_pc,
    input  logic            fetch_rdy,
    output logic            busy
);

    fetch_state_t           state;
    logic [PC_W-1:0]        pc;
    logic [PC_W-1:0]        pend_pc;
    logic                   pend;
    logic                   kill;

    fetch_entry_t           q_din;
    fetch_entry_t           q_head;
    logic                   q_empty;
    logic [FETCH_CNT_W-1:0] q_count;

    logic                   pop;
    logic                   flush;
    logic                   push;
    logic [2:0]             occ;

    // Issue when the slot will be free by the time the data returns.
    always_comb begin
        pop      = !q_empty & fetch_rdy;
        flush    = (state == RUN) & (redirect_vld | halt);
        push     = pend & !kill & !flush;
        occ      = 3'(q_count) + 3'(pend & !kill);
        rom_en   = (state == RUN) && ((occ - 3'(pop)) < 3'(Q_N));
        rom_addr = pc;
        q_din.inst = rom_dout;
        q_din.pc   = pc_t'(pend_pc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            pend_pc <= '0;
            pend    <= 1'b0;
            kill    <= 1'b0;
        end else begin
            pend <= rom_en;
            kill <= rom_en & flush;
            if (rom_en) pend_pc <= pc;
            case (state)
                IDLE: begin
                    if (start_vld) begin
                        state <= RUN;
                        pc    <= start_pc;
                    end
                end
                RUN: begin
                    if (halt)              state <= IDLE;
                    else if (redirect_vld) pc    <= redirect_pc;
                    else if (rom_en)       pc    <= PC_W'(pc + 1'b1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    qs_srt_fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (q_din),
        .pop       (pop),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign fetch_vld  = !q_empty;
    assign fetch_inst = q_head.inst;
    assign fetch_pc   = PC_W'(q_head.pc);
    assign start_rdy  = (state == IDLE);
    assign busy       = (state == RUN);

endmodule

// File: tb/tb_qs_srt_fetch.sv
// Scoreboard bench for qs_srt_fetch with a 1-cycle-latency ROM model.
module tb_qs_srt_fetch;
    import qs_srt_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start_vld, rom_en, redirect_vld, halt, fetch_vld, fetch_rdy;
    logic        start_rdy, busy;
    logic [7:0]  start_pc, rom_addr, redirect_pc, fetch_pc;
    inst_t       rom_dout, fetch_inst;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;

    logic [7:0] sb[$];
    bit         run_m = 0;
    int         occ_m = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_pc;
    inst_t      prev_inst;

    always #5 clk = ~clk;

    qs_srt_fetch #(.PC_W(8), .Q_N(2)) dut (
        .clk(clk), .rst(rst),
        .start_vld(start_vld), .start_pc(start_pc), .start_rdy(start_rdy),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .halt(halt),
        .fetch_vld(fetch_vld), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
        .fetch_rdy(fetch_rdy), .busy(busy)
    );

    function automatic inst_t rom_word(input logic [7:0] a);
        return {16'hC0DE, ~a, a};
    endfunction

    always @(posedge clk) if (rom_en) rom_dout <= rom_word(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_sb(input logic [7:0] first);
        logic [7:0] p;
        p = first;
        sb.delete();
        for (int i = 0; i < 256; i++) begin
            sb.push_back(p);
            p = p + 8'd1;
        end
    endtask

    // Check one cycle's outputs against the model, then advance the model.
    task automatic tick();
        logic       pop_m;
        logic [7:0] e;
        bit         exp_en;
        #1;
        pop_m = fetch_vld && fetch_rdy;
        if (prev_stall) begin
            check("hold_pc", 32'(fetch_pc), 32'(prev_pc));
            check("hold_inst", fetch_inst, prev_inst);
        end
        exp_en = run_m && ((occ_m - int'(pop_m)) < 2);
        check("rom_en_rule", 32'(rom_en), 32'(exp_en));
        if (pop_m) begin
            n_pop++;
            if (sb.size() == 0) begin
                check("sb_empty", 32'(fetch_pc), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("fetch_pc", 32'(fetch_pc), 32'(e));
                check("fetch_inst", fetch_inst, rom_word(e));
            end
        end
        prev_stall = fetch_vld && !fetch_rdy && !rst && !(run_m && (halt || redirect_vld));
        prev_pc    = fetch_pc;
        prev_inst  = fetch_inst;
        if (rst) begin
            run_m = 0; occ_m = 0; sb.delete();
        end else if (!run_m && start_vld) begin
            run_m = 1; occ_m = 0; load_sb(start_pc);
        end else if (run_m && halt) begin
            run_m = 0; occ_m = 0; sb.delete();
        end else if (run_m && redirect_vld) begin
            occ_m = 0; load_sb(redirect_pc);
        end else if (run_m) begin
            occ_m = occ_m + int'(rom_en) - int'(pop_m);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rom_en"},     32'(rom_en), 32'd0);
        check({tag, "_rom_addr"},   32'(rom_addr), 32'd0);
        check({tag, "_fetch_vld"},  32'(fetch_vld), 32'd0);
        check({tag, "_fetch_inst"}, fetch_inst, 32'd0);
        check({tag, "_fetch_pc"},   32'(fetch_pc), 32'd0);
        check({tag, "_start_rdy"},  32'(start_rdy), 32'd1);
        check({tag, "_busy"},       32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, waited;
        rst = 1; start_vld = 0; start_pc = '0; redirect_vld = 0; redirect_pc = '0;
        halt = 0; fetch_rdy = 0;
        @(negedge clk);
        repeat (2) tick();
        rst = 0;
        #1 check_reset_vals("reset");

        // Straight-line from 0x10 with decode always ready
        start_pc = 8'h10; start_vld = 1; fetch_rdy = 1;
        #1 check("start_rdy", 32'(start_rdy), 32'd1);
        tick();
        start_vld = 0;
        #1;
        check("t1_rom_en", 32'(rom_en), 32'd1);
        check("t1_rom_addr", 32'(rom_addr), 32'h10);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_fetch_vld", 32'(fetch_vld), 32'd0);
        tick();
        #1 check("t2_fetch_vld", 32'(fetch_vld), 32'd0);
        tick();
        #1 check("t3_fetch_vld", 32'(fetch_vld), 32'd1);
        check("t3_fetch_pc", 32'(fetch_pc), 32'h10);
        tick();
        repeat (10) begin
            #1 check("no_bubble", 32'(fetch_vld), 32'd1);
            tick();
        end

        // Random back-pressure
        base = n_pop;
        repeat (200) begin
            fetch_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        check("bp_progress", 32'(n_pop - base > 50), 32'd1);

        // Redirect with a full queue
        fetch_rdy = 0;
        repeat (3) tick();
        redirect_pc = 8'h40; redirect_vld = 1;
        tick();
        redirect_vld = 0; fetch_rdy = 1;
        #1;
        check("r1_fetch_vld", 32'(fetch_vld), 32'd0);
        check("r1_rom_en", 32'(rom_en), 32'd1);
        check("r1_rom_addr", 32'(rom_addr), 32'h40);
        tick();
        #1 check("r2_fetch_vld", 32'(fetch_vld), 32'd0);
        tick();
        #1 check("r3_fetch_vld", 32'(fetch_vld), 32'd1);
        check("r3_fetch_pc", 32'(fetch_pc), 32'h40);
        repeat (5) tick();

        // PC wrap from 0xFE
        halt = 1;
        tick();
        halt = 0;
        #1 check("halt_busy", 32'(busy), 32'd0);
        tick();
        base = n_pop;
        start_pc = 8'hFE; start_vld = 1;
        tick();
        start_vld = 0;
        repeat (8) tick();
        check("wrap_count", 32'(n_pop - base >= 4), 32'd1);

        // Halt and redirect together, then restart at 0x20
        halt = 1; redirect_vld = 1; redirect_pc = 8'h77;
        tick();
        halt = 0; redirect_vld = 0;
        #1;
        check("h1_busy", 32'(busy), 32'd0);
        check("h1_start_rdy", 32'(start_rdy), 32'd1);
        check("h1_fetch_vld", 32'(fetch_vld), 32'd0);
        check("h1_rom_en", 32'(rom_en), 32'd0);
        repeat (3) begin
            tick();
            #1 check("idle_fetch_vld", 32'(fetch_vld), 32'd0);
        end
        start_pc = 8'h20; start_vld = 1;
        tick();
        start_vld = 0;
        waited = 0;
        while (!fetch_vld && waited < 10) begin
            tick();
            waited++;
        end
        check("restart_seen", 32'(fetch_vld), 32'd1);
        check("restart_pc", 32'(fetch_pc), 32'h20);
        repeat (4) tick();

        // Reset mid-run with a read in flight
        rst = 1;
        #1 check("rst_read_issued", 32'(rom_en), 32'd1);
        tick();
        rst = 0;
        #1 check_reset_vals("midrst");
        repeat (3) begin
            tick();
            #1;
            check("post_rst_vld", 32'(fetch_vld), 32'd0);
            check("post_rst_inst", fetch_inst, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
